// File: rtl/seq_det_pkg.sv
// Shared defaults, legal ranges and datapath action codes for the serial
// pattern detector.
package seq_det_pkg;

  localparam int SEQ_N_MIN     = 2;
  localparam int SEQ_N_MAX     = 16;
  localparam int SEQ_N_DEF     = 4;
  localparam int SEQ_CNT_W_DEF = 8;

  localparam logic [SEQ_N_MAX-1:0] SEQ_PAT_DEF = 16'h000B;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_SAMPLE,
    ACT_LOAD
  } seq_act_e;

  function automatic bit n_is_legal(input int n);
    return (n >= SEQ_N_MIN) && (n <= SEQ_N_MAX);
  endfunction

endpackage

// File: rtl/seq_detector_param_if.sv
// Serial data / pattern-load / match-status signals of the detector.
interface seq_detector_param_if
  import seq_det_pkg::*;
#(
  parameter int N     = SEQ_N_DEF,
  parameter int CNT_W = SEQ_CNT_W_DEF
);

  logic             en;
  logic             x;
  logic             load;
  logic [N-1:0]     pattern_in;
  logic             clr_cnt;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output en, x, load, pattern_in, clr_cnt,
    input  z, match_cnt, cnt_sat
  );

  modport slave (
    input  en, x, load, pattern_in, clr_cnt,
    output z, match_cnt, cnt_sat
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with a sticky saturation flag and synchronous clear.
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int CNT_W = SEQ_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // A clear on the same edge as an increment counts that increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= inc ? CNT_W'(1) : '0;
      sat <= 1'b0;
    end else if (inc) begin
      if (cnt == CNT_MAX) begin
        sat <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector with loadable pattern, optional
// overlapping matches and a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             N        = SEQ_N_DEF,
  parameter logic [N-1:0]   PAT_INIT = SEQ_PAT_DEF[N-1:0],
  parameter int             OVERLAP  = 1,
  parameter int             CNT_W    = SEQ_CNT_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  seq_detector_param_if.slave bus
);

  if (!n_is_legal(N)) begin : g_bad_n
    $error("seq_detector_param: N=%0d is outside the legal range", N);
  end

  localparam int               FILL_W    = $clog2(N + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

  // Only the newest N-1 bits are kept; the oldest would fall off on the next sample.
  logic [N-2:0]      hist, hist_d;
  logic [N-1:0]      hist_nxt;
  logic [N-1:0]      pat, pat_d;
  logic [FILL_W-1:0] fill, fill_d, fill_inc;
  logic              z_q, z_d;
  logic              match;
  seq_act_e          act;

  always_comb begin
    act      = ACT_HOLD;
    hist_nxt = {hist, bus.x};
    fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    match    = 1'b0;
    hist_d   = hist;
    fill_d   = fill;
    pat_d    = pat;
    z_d      = 1'b0;

    if (bus.load) begin
      act = ACT_LOAD;
    end else if (bus.en) begin
      act = ACT_SAMPLE;
    end

    unique case (act)
      ACT_LOAD: begin
        pat_d  = bus.pattern_in;
        fill_d = '0;
      end
      ACT_SAMPLE: begin
        hist_d = hist_nxt[N-2:0];
        match  = (fill_inc == FILL_FULL) && (hist_nxt == pat);
        // Non-overlapping mode forces the next match to start from scratch.
        fill_d = (match && (OVERLAP == 0)) ? '0 : fill_inc;
        z_d    = match;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
      pat  <= PAT_INIT;
      z_q  <= 1'b0;
    end else begin
      hist <= hist_d;
      fill <= fill_d;
      pat  <= pat_d;
      z_q  <= z_d;
    end
  end

  assign bus.z = z_q;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (match),
    .clr (bus.clr_cnt),
    .cnt (bus.match_cnt),
    .sat (bus.cnt_sat)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed table-driven bench for seq_detector_param across four configurations.
module tb_seq_detector_param;
  import seq_det_pkg::*;

  typedef struct {
    logic       en;
    logic       x;
    logic       load;
    logic [3:0] pat;
    logic       clr;
    logic       ez;
    logic [7:0] ecnt;
    logic       esat;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // dut0: N=4 overlap, dut1: N=4 non-overlap, dut2: N=3, dut3: CNT_W=2
  seq_detector_param_if #(.N(4), .CNT_W(8)) b0 ();
  seq_detector_param_if #(.N(4), .CNT_W(8)) b1 ();
  seq_detector_param_if #(.N(3), .CNT_W(8)) b2 ();
  seq_detector_param_if #(.N(4), .CNT_W(2)) b3 ();

  seq_detector_param #(.N(4), .OVERLAP(1), .CNT_W(8)) u0 (.clk(clk), .rst(rst), .bus(b0));
  seq_detector_param #(.N(4), .OVERLAP(0), .CNT_W(8)) u1 (.clk(clk), .rst(rst), .bus(b1));
  seq_detector_param #(.N(3), .OVERLAP(1), .CNT_W(8)) u2 (.clk(clk), .rst(rst), .bus(b2));
  seq_detector_param #(.N(4), .OVERLAP(1), .CNT_W(2)) u3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t tab_a[$];
  vec_t tab_b[$];
  vec_t tab_c[$];
  vec_t tab_d[$];

  logic [6:0] strm_ab = 7'b1011011;
  logic [6:0] z_a     = 7'b0001001;
  logic [6:0] z_b     = 7'b0001000;
  int         cnt_a[7] = '{0, 0, 0, 1, 1, 1, 2};
  int         cnt_b[7] = '{0, 0, 0, 1, 1, 1, 1};
  logic [4:0] strm_c  = 5'b10101;
  logic [4:0] z_c     = 5'b00101;
  int         cnt_c[5] = '{0, 0, 1, 1, 2};
  int         cnt_d[6] = '{0, 1, 2, 3, 3, 3};
  logic       sat_d[6] = '{0, 0, 0, 0, 1, 1};
  int         cnt_e[5] = '{0, 1, 2, 3, 3};
  logic       sat_e[5] = '{0, 0, 0, 0, 1};

  function automatic vec_t mk(input logic en, input logic x, input logic load,
                              input logic [3:0] pat, input logic clr,
                              input logic ez, input int ecnt, input logic esat);
    vec_t r;
    r.en   = en;
    r.x    = x;
    r.load = load;
    r.pat  = pat;
    r.clr  = clr;
    r.ez   = ez;
    r.ecnt = 8'(ecnt);
    r.esat = esat;
    return r;
  endfunction

  task automatic driveOnly(input int dut, input vec_t v);
    case (dut)
      0: begin b0.en = v.en; b0.x = v.x; b0.load = v.load; b0.pattern_in = v.pat;      b0.clr_cnt = v.clr; end
      1: begin b1.en = v.en; b1.x = v.x; b1.load = v.load; b1.pattern_in = v.pat;      b1.clr_cnt = v.clr; end
      2: begin b2.en = v.en; b2.x = v.x; b2.load = v.load; b2.pattern_in = v.pat[2:0]; b2.clr_cnt = v.clr; end
      default: begin b3.en = v.en; b3.x = v.x; b3.load = v.load; b3.pattern_in = v.pat; b3.clr_cnt = v.clr; end
    endcase
  endtask

  // Drive one vector, let one rising edge take it, then sample 1 time unit later.
  task automatic applyStimulus(input int dut, input vec_t v);
    driveOnly(dut, v);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int dut, input vec_t v, input string tag);
    logic       az;
    logic [7:0] ac;
    logic       as;
    case (dut)
      0: begin az = b0.z; ac = b0.match_cnt; as = b0.cnt_sat; end
      1: begin az = b1.z; ac = b1.match_cnt; as = b1.cnt_sat; end
      2: begin az = b2.z; ac = b2.match_cnt; as = b2.cnt_sat; end
      default: begin az = b3.z; ac = {6'b0, b3.match_cnt}; as = b3.cnt_sat; end
    endcase
    total++;
    if (az !== v.ez) begin
      bad++;
      $display("[TB] FAIL %s z: got %0b want %0b", tag, az, v.ez);
    end
    total++;
    if (ac !== v.ecnt) begin
      bad++;
      $display("[TB] FAIL %s match_cnt: got %0d want %0d", tag, ac, v.ecnt);
    end
    total++;
    if (as !== v.esat) begin
      bad++;
      $display("[TB] FAIL %s cnt_sat: got %0b want %0b", tag, as, v.esat);
    end
  endtask

  task automatic runTable(input int dut, input vec_t tab[$], input string name);
    for (int i = 0; i < tab.size(); i++) begin
      applyStimulus(dut, tab[i]);
      checkOutput(dut, tab[i], $sformatf("%s[%0d]", name, i));
    end
  endtask

  initial begin
    vec_t idle;
    vec_t v;
    total = 0;
    bad   = 0;
    idle  = mk(0, 0, 0, 4'b0000, 0, 0, 0, 0);

    for (int i = 0; i < 7; i++) begin
      tab_a.push_back(mk(1, strm_ab[6-i], 0, 4'b0000, 0, z_a[6-i], cnt_a[i], 0));
      tab_b.push_back(mk(1, strm_ab[6-i], 0, 4'b0000, 0, z_b[6-i], cnt_b[i], 0));
    end
    tab_a.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 2, 0));
    tab_b.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 1, 0));

    // Load with en=1 on the same edge: the x=1 must be discarded.
    tab_c.push_back(mk(1, 1, 1, 4'b0101, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      tab_c.push_back(mk(1, strm_c[4-i], 0, 4'b0000, 0, z_c[4-i], cnt_c[i], 0));
    end
    tab_c.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 2, 0));

    tab_d.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 0));
    tab_d.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0));
    tab_d.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 0, 0));
    tab_d.push_back(mk(1, 1, 0, 4'b0000, 0, 1, 1, 0));
    for (int k = 2; k <= 5; k++) begin
      tab_d.push_back(mk(1, 0, 0, 4'b0000, 0, 0, cnt_d[k-1], sat_d[k-1]));
      tab_d.push_back(mk(1, 1, 0, 4'b0000, 0, 0, cnt_d[k-1], sat_d[k-1]));
      tab_d.push_back(mk(1, 1, 0, 4'b0000, 0, 1, cnt_d[k],   sat_d[k]));
    end
    tab_d.push_back(mk(0, 0, 0, 4'b0000, 1, 0, 0, 0));
    for (int k = 1; k <= 4; k++) begin
      tab_d.push_back(mk(1, 0, 0, 4'b0000, 0, 0, cnt_e[k-1], sat_e[k-1]));
      tab_d.push_back(mk(1, 1, 0, 4'b0000, 0, 0, cnt_e[k-1], sat_e[k-1]));
      tab_d.push_back(mk(1, 1, 0, 4'b0000, 0, 1, cnt_e[k],   sat_e[k]));
    end
    tab_d.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 3, 1));
    tab_d.push_back(mk(1, 1, 0, 4'b0000, 0, 0, 3, 1));
    tab_d.push_back(mk(1, 1, 0, 4'b0000, 1, 1, 1, 0));
    tab_d.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 1, 0));

    rst = 1'b0;
    for (int d = 0; d < 4; d++) driveOnly(d, idle);
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) checkOutput(d, idle, $sformatf("reset_dut%0d", d));
    rst = 1'b1;

    runTable(0, tab_a, "overlap");
    runTable(1, tab_b, "nonoverlap");
    runTable(2, tab_c, "n3_load");
    runTable(3, tab_d, "saturate");

    // Load a foreign pattern, start a partial match, then reset mid-sequence.
    applyStimulus(0, mk(0, 0, 1, 4'b0110, 0, 0, 2, 0));
    checkOutput(0, mk(0, 0, 1, 4'b0110, 0, 0, 2, 0), "load_pat");
    applyStimulus(0, mk(1, 1, 0, 4'b0000, 0, 0, 2, 0));
    applyStimulus(0, mk(1, 0, 0, 4'b0000, 0, 0, 2, 0));
    v = mk(1, 1, 0, 4'b0000, 0, 0, 2, 0);
    applyStimulus(0, v);
    checkOutput(0, v, "pre_reset");
    driveOnly(0, idle);
    rst = 1'b0;
    #1;
    checkOutput(0, idle, "async_reset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    v = mk(1, 1, 0, 4'b0000, 0, 0, 0, 0);
    applyStimulus(0, v);
    checkOutput(0, v, "post_reset_bit1");
    v = mk(1, 0, 0, 4'b0000, 0, 0, 0, 0);
    applyStimulus(0, v);
    checkOutput(0, v, "post_reset_bit2");
    v = mk(1, 1, 0, 4'b0000, 0, 0, 0, 0);
    applyStimulus(0, v);
    checkOutput(0, v, "post_reset_bit3");
    v = mk(1, 1, 0, 4'b0000, 0, 1, 1, 0);
    applyStimulus(0, v);
    checkOutput(0, v, "pat_init_restored");
    applyStimulus(0, mk(0, 0, 0, 4'b0000, 0, 0, 1, 0));
    checkOutput(0, mk(0, 0, 0, 4'b0000, 0, 0, 1, 0), "pulse_end");

    // Fresh start, then stall with en=0 (and a junk x) between bits 2 and 3.
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    v = mk(1, 1, 0, 4'b0000, 0, 0, 0, 0);
    applyStimulus(0, v);
    checkOutput(0, v, "stall_bit1");
    v = mk(1, 0, 0, 4'b0000, 0, 0, 0, 0);
    applyStimulus(0, v);
    checkOutput(0, v, "stall_bit2");
    for (int s = 0; s < 3; s++) begin
      v = mk(0, 1, 0, 4'b0000, 0, 0, 0, 0);
      applyStimulus(0, v);
      checkOutput(0, v, $sformatf("stall_hold%0d", s));
    end
    v = mk(1, 1, 0, 4'b0000, 0, 0, 0, 0);
    applyStimulus(0, v);
    checkOutput(0, v, "stall_bit3");
    v = mk(1, 1, 0, 4'b0000, 0, 1, 1, 0);
    applyStimulus(0, v);
    checkOutput(0, v, "stall_bit4");
    applyStimulus(0, mk(0, 0, 0, 4'b0000, 0, 0, 1, 0));
    checkOutput(0, mk(0, 0, 0, 4'b0000, 0, 0, 1, 0), "stall_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
